// File: rtl/dcache_flush_ctrl.sv
// Write-back / refill sequencer for one data-cache line; owns the line flush port and memory port.
// Optional build macro DCACHE_FLUSH_CRITICAL_WORD_FIRST_EN starts the refill at the missed word.
//
// state   | meaning
// IDLE    | waiting for a CPU access that misses the line
// WB_RD   | present write-back word address to the line
// WB_WR   | memory write of the captured line word, wait for ack
// FILL_RD | memory read of the next refill word, wait for ack
// FILL_WE | write the refill word into the line
// DONE    | release the line port so its miss status re-evaluates
module dcache_flush_ctrl #(
    parameter int DATABITS      = 32,
    parameter int ADDRBITS      = 32,
    parameter int CACHEADDRBITS = 5
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [ADDRBITS-1:0]                 dcache_addr,
    input  logic                                dcache_rdreq,
    input  logic                                dcache_wrreq,
    output logic                                dcache_stall,
    input  logic                                line_miss,
    input  logic                                line_dirty,
    input  logic [ADDRBITS-CACHEADDRBITS-3:0]   line_tag,
    input  logic [DATABITS-1:0]                 line_out,
    output logic                                flush_mode,
    output logic                                flush_we,
    output logic [ADDRBITS-1:0]                 flush_addr,
    output logic [DATABITS-1:0]                 flush_in,
    output logic [ADDRBITS-1:0]                 mem_addr,
    output logic                                mem_rdreq,
    output logic                                mem_wrreq,
    output logic [DATABITS-1:0]                 mem_out,
    input  logic [DATABITS-1:0]                 mem_in,
    input  logic                                mem_ack
);

    localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - 2;
    localparam logic [CACHEADDRBITS-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_RD   = 3'd1,
        WB_WR   = 3'd2,
        FILL_RD = 3'd3,
        FILL_WE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                     state, state_nxt;
    logic [CACHEADDRBITS-1:0]   cnt, cnt_nxt;
    logic [CACHEADDRBITS-1:0]   start, start_nxt;
    logic [CACHEADDRBITS-1:0]   idx_nxt;
    logic [TAGBITS-1:0]         new_tag, new_tag_nxt;
    logic [TAGBITS-1:0]         old_tag, old_tag_nxt;
    logic [DATABITS-1:0]        wb_data, wb_data_nxt;
    logic [DATABITS-1:0]        fill_data, fill_data_nxt;

    logic                       flush_mode_nxt;
    logic                       flush_we_nxt;
    logic [ADDRBITS-1:0]        flush_addr_nxt;
    logic [DATABITS-1:0]        flush_in_nxt;
    logic [ADDRBITS-1:0]        mem_addr_nxt;
    logic                       mem_rdreq_nxt;
    logic                       mem_wrreq_nxt;
    logic [DATABITS-1:0]        mem_out_nxt;

    logic                       trigger;
    logic                       unused_addr_bits;

    assign trigger          = (dcache_rdreq | dcache_wrreq) & line_miss;
    assign dcache_stall     = (state != IDLE) | trigger;
    assign unused_addr_bits = ^dcache_addr[1:0];

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        start_nxt     = start;
        new_tag_nxt   = new_tag;
        old_tag_nxt   = old_tag;
        wb_data_nxt   = wb_data;
        fill_data_nxt = fill_data;
        case (state)
            IDLE: begin
                if (trigger) begin
                    new_tag_nxt = dcache_addr[ADDRBITS-1:CACHEADDRBITS+2];
                    old_tag_nxt = line_tag;
                    start_nxt   = dcache_addr[CACHEADDRBITS+1:2];
                    cnt_nxt     = '0;
                    state_nxt   = line_dirty ? WB_RD : FILL_RD;
                end
            end
            WB_RD: begin
                wb_data_nxt = line_out;
                state_nxt   = WB_WR;
            end
            WB_WR: begin
                if (mem_ack) begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt   = '0;
                        state_nxt = FILL_RD;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = WB_RD;
                    end
                end
            end
            FILL_RD: begin
                if (mem_ack) begin
                    fill_data_nxt = mem_in;
                    state_nxt     = FILL_WE;
                end
            end
            FILL_WE: begin
                if (cnt == CNT_MAX) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = FILL_RD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DCACHE_FLUSH_CRITICAL_WORD_FIRST_EN
    assign idx_nxt = start_nxt + cnt_nxt;
`else
    assign idx_nxt = cnt_nxt;
`endif

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        flush_mode_nxt = 1'b0;
        flush_we_nxt   = 1'b0;
        flush_addr_nxt = '0;
        flush_in_nxt   = '0;
        mem_addr_nxt   = '0;
        mem_rdreq_nxt  = 1'b0;
        mem_wrreq_nxt  = 1'b0;
        mem_out_nxt    = '0;
        case (state_nxt)
            WB_RD: begin
                flush_mode_nxt = 1'b1;
                flush_addr_nxt = {old_tag_nxt, cnt_nxt, 2'b00};
            end
            WB_WR: begin
                flush_mode_nxt = 1'b1;
                mem_wrreq_nxt  = 1'b1;
                mem_addr_nxt   = {old_tag_nxt, cnt_nxt, 2'b00};
                mem_out_nxt    = wb_data_nxt;
            end
            FILL_RD: begin
                flush_mode_nxt = 1'b1;
                mem_rdreq_nxt  = 1'b1;
                mem_addr_nxt   = {new_tag_nxt, idx_nxt, 2'b00};
            end
            FILL_WE: begin
                flush_mode_nxt = 1'b1;
                flush_we_nxt   = 1'b1;
                flush_addr_nxt = {new_tag_nxt, idx_nxt, 2'b00};
                flush_in_nxt   = fill_data_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            start      <= '0;
            new_tag    <= '0;
            old_tag    <= '0;
            wb_data    <= '0;
            fill_data  <= '0;
            flush_mode <= 1'b0;
            flush_we   <= 1'b0;
            flush_addr <= '0;
            flush_in   <= '0;
            mem_addr   <= '0;
            mem_rdreq  <= 1'b0;
            mem_wrreq  <= 1'b0;
            mem_out    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            start      <= start_nxt;
            new_tag    <= new_tag_nxt;
            old_tag    <= old_tag_nxt;
            wb_data    <= wb_data_nxt;
            fill_data  <= fill_data_nxt;
            flush_mode <= flush_mode_nxt;
            flush_we   <= flush_we_nxt;
            flush_addr <= flush_addr_nxt;
            flush_in   <= flush_in_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_rdreq  <= mem_rdreq_nxt;
            mem_wrreq  <= mem_wrreq_nxt;
            mem_out    <= mem_out_nxt;
        end
    end

    a_req_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_rdreq && mem_wrreq));
    a_rdreq_held: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_rdreq && !mem_ack) |=> (mem_rdreq && $stable(mem_addr)));
    a_wrreq_held: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_wrreq && !mem_ack) |=> (mem_wrreq && $stable(mem_addr) && $stable(mem_out)));

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Scoreboard bench for dcache_flush_ctrl: stimulus queues expected memory/line transactions,
// a monitor pops and compares them as the controller issues them.
module tb_dcache_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] dcache_addr;
    logic        dcache_rdreq, dcache_wrreq, dcache_stall;
    logic        line_miss, line_dirty;
    logic [24:0] line_tag;
    logic [31:0] line_out;
    logic        flush_mode, flush_we;
    logic [31:0] flush_addr, flush_in, mem_addr, mem_out, mem_in;
    logic        mem_rdreq, mem_wrreq, mem_ack;

    always #5 clk = ~clk;

    dcache_flush_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .dcache_addr(dcache_addr), .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .dcache_stall(dcache_stall),
        .line_miss(line_miss), .line_dirty(line_dirty), .line_tag(line_tag), .line_out(line_out),
        .flush_mode(flush_mode), .flush_we(flush_we), .flush_addr(flush_addr), .flush_in(flush_in),
        .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
        .mem_out(mem_out), .mem_in(mem_in), .mem_ack(mem_ack)
    );

    // Line model: combinational read, contents derived from the word address.
    assign line_out = 32'h5A00_0000 ^ flush_addr;

    typedef struct {
        int          kind;   // 0 write-back, 1 fill read, 2 line write
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   ack_delay = 0;
    int   req_age = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic pop_check(input string name, input int kind, input logic [31:0] a,
                             input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got transaction at %h, required none", name, a);
        end else begin
            e = exp_q.pop_front();
            check(name, {8'(kind), a, d}, {8'(e.kind), e.addr, e.data});
        end
    endtask

    // Memory responder: acks after ack_delay extra cycles of a held request.
    initial begin
        mem_ack = 1'b0;
        mem_in  = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (reset_n && (mem_rdreq || mem_wrreq)) begin
                if (req_age == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_in  = mem_word(mem_addr);
                    req_age = 0;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed transfer and line write.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (mem_rdreq || mem_wrreq)
                    check("req_exclusive", 72'(mem_rdreq & mem_wrreq), 72'(0));
                if (mem_ack && mem_wrreq) pop_check("wb_write", 0, mem_addr, mem_out);
                if (mem_ack && mem_rdreq) pop_check("fill_read", 1, mem_addr, 32'h0);
                if (flush_we)             pop_check("fill_line_we", 2, flush_addr, flush_in);
            end
        end
    end

    task automatic push_expected(input logic [31:0] addr, input logic [24:0] otag, input logic dirty);
        logic [24:0] ntag;
        logic [4:0]  st;
        logic [4:0]  idx;
        logic [31:0] a;
        ntag = addr[31:7];
        st   = addr[6:2];
        if (dirty) begin
            for (int i = 0; i < 32; i++) begin
                a = {otag, 5'(i), 2'b00};
                exp_q.push_back('{kind: 0, addr: a, data: 32'h5A00_0000 ^ a});
            end
        end
        for (int i = 0; i < 32; i++) begin
            idx = 5'(i);
`ifdef DCACHE_FLUSH_CRITICAL_WORD_FIRST_EN
            idx = st + 5'(i);
`endif
            a = {ntag, idx, 2'b00};
            exp_q.push_back('{kind: 1, addr: a, data: 32'h0});
            exp_q.push_back('{kind: 2, addr: a, data: mem_word(a)});
        end
    endtask

    task automatic run_miss(input string name, input logic [31:0] addr, input logic [24:0] otag,
                            input logic dirty, input logic use_wr, input int dly,
                            input int exp_cycles, input bit drop_mid);
        int  cycles;
        int  guard;
        bit  busy;
        push_expected(addr, otag, dirty);
        @(negedge clk);
        ack_delay    = dly;
        dcache_addr  = addr;
        line_tag     = otag;
        line_dirty   = dirty;
        line_miss    = 1'b1;
        dcache_rdreq = !use_wr;
        dcache_wrreq = use_wr;
        #1;
        cycles = 0;
        guard  = 0;
        busy   = 1'b0;
        while (dcache_stall && guard < 1000) begin
            cycles++;
            if (flush_mode) busy = 1'b1;
            else if (busy) line_miss = 1'b0;
            if (drop_mid && cycles == 10) begin
                dcache_rdreq = 1'b0;
                dcache_wrreq = 1'b0;
            end
            @(negedge clk);
            #1;
            guard++;
        end
        dcache_rdreq = 1'b0;
        dcache_wrreq = 1'b0;
        check({name, "_finished"}, 72'(guard < 1000), 72'(1));
        check({name, "_stall_cycles"}, 72'(cycles), 72'(exp_cycles));
        check({name, "_queue_drained"}, 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        reset_n      = 1'b0;
        dcache_addr  = '0;
        dcache_rdreq = 1'b0;
        dcache_wrreq = 1'b0;
        line_miss    = 1'b0;
        line_dirty   = 1'b0;
        line_tag     = '0;
        #12;
        check("reset_ctrl_outputs",
              {67'(0), flush_mode, flush_we, mem_rdreq, mem_wrreq, dcache_stall}, 72'(0));
        check("reset_addr_outputs", {8'(0), flush_addr, mem_addr}, 72'(0));
        check("reset_data_outputs", {8'(0), flush_in, mem_out}, 72'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Hits: the controller must stay idle.
        @(negedge clk);
        dcache_addr  = 32'h0000_2000;
        dcache_rdreq = 1'b1;
        line_miss    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hit_stall", 72'(dcache_stall), 72'(0));
            check("hit_idle", {69'(0), flush_mode, mem_rdreq, mem_wrreq}, 72'(0));
            if (i == 1) begin
                dcache_rdreq = 1'b0;
                dcache_wrreq = 1'b1;
            end
            @(negedge clk);
        end
        dcache_wrreq = 1'b0;

        run_miss("clean_miss", 32'h0000_1084, 25'h000_0033, 1'b0, 1'b0, 0, 66, 1'b0);
        run_miss("dirty_miss", 32'h0000_1084, 25'h000_0005, 1'b1, 1'b0, 0, 130, 1'b0);
        run_miss("slow_clean", 32'h0000_1084, 25'h000_0005, 1'b0, 1'b0, 3, 162, 1'b1);
        run_miss("slow_dirty_wr", 32'h0000_3010, 25'h000_0007, 1'b1, 1'b1, 3, 322, 1'b0);
        run_miss("top_addr_dirty", 32'hFFFF_FFFC, 25'h1FF_FFFF, 1'b1, 1'b0, 0, 130, 1'b0);

        // Reset asserted while a write-back request is outstanding.
        push_expected(32'h0000_1084, 25'h000_0005, 1'b1);
        @(negedge clk);
        ack_delay    = 2;
        dcache_addr  = 32'h0000_1084;
        line_tag     = 25'h000_0005;
        line_dirty   = 1'b1;
        line_miss    = 1'b1;
        dcache_rdreq = 1'b1;
        guard = 0;
        while (!mem_wrreq && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reset_test_reached_wb_wr", 72'(mem_wrreq), 72'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_drops_wrreq", 72'(mem_wrreq), 72'(0));
        check("reset_drops_flush_mode", 72'(flush_mode), 72'(0));
        exp_q.delete();
        dcache_rdreq = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("post_reset_idle",
                  {68'(0), dcache_stall, flush_mode, mem_rdreq, mem_wrreq}, 72'(0));
        end
        run_miss("after_reset_clean", 32'h0000_0000, 25'h000_0001, 1'b0, 1'b0, 0, 66, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_flush_ctrl.md
# dcache_flush_ctrl

Sequencer for one `dcache_line`: on a CPU access that misses, it writes the dirty line back to main memory, then refills the line from the new memory section. It drives the line's flush port, stalls the CPU while busy, and owns the single-word main-memory request/acknowledge interface. One instance sits beside each data-cache line, between the core's data port and the memory arbiter.

## Interface
- `DATABITS`, 32, data word width
- `ADDRBITS`, 32, byte address width
- `CACHEADDRBITS`, 5, log2 of words per line (line = 2^CACHEADDRBITS words)
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `dcache_addr`  in  ADDRBITS  CPU byte address
- `dcache_rdreq` / `dcache_wrreq`  in  1  CPU read / write request
- `dcache_stall`  out  1  CPU must hold its request while high
- `line_miss`, `line_dirty`  in  1  line status
- `line_tag`  in  ADDRBITS-CACHEADDRBITS-2  memory section currently held by the line
- `line_out`  in  DATABITS  line read data; valid one cycle after `flush_addr` changes
- `flush_mode`  out  1  line port owned by controller
- `flush_we`  out  1  write `flush_in` at `flush_addr`
- `flush_addr`  out  ADDRBITS  word address into the line (tag + index, bits[1:0]=0)
- `flush_in`  out  DATABITS  refill data
- `mem_addr`  out  ADDRBITS  memory word address, bits[1:0]=0
- `mem_rdreq` / `mem_wrreq`  out  1  memory read / write request, held until ack
- `mem_out`  out  DATABITS  write-back data
- `mem_in`  in  DATABITS  read data, valid with `mem_ack` on a read
- `mem_ack`  in  1  one-cycle completion pulse

## Operation
- Register-based FSM with states IDLE, WB_RD, WB_WR, FILL_RD, FILL_WE and DONE, plus a word counter `cnt` of width CACHEADDRBITS.
- **IDLE.** Triggered when `(dcache_rdreq|dcache_wrreq) & line_miss`.
  - Latch `new_tag = dcache_addr[ADDRBITS-1:CACHEADDRBITS+2]`.
  - Latch `old_tag = line_tag`.
  - Latch `start = dcache_addr[CACHEADDRBITS+1:2]`.
  - Go to WB_RD if `line_dirty`, else to FILL_RD.
  - Load `cnt` with 0 in either case.
- **WB_RD.** Drive `flush_addr = {old_tag,cnt,2'b00}` for one cycle, then go to WB_WR.
- **WB_WR.** Drive `mem_wrreq=1`, `mem_addr={old_tag,cnt,2'b00}` and `mem_out=line_out`, where `line_out` is captured in the WB_RD→WB_WR transition.
  - On `mem_ack`: if `cnt` is at its maximum, clear `cnt` and go to FILL_RD; else increment `cnt` and go to WB_RD.
- **FILL_RD.** Drive `mem_rdreq=1`, `mem_addr={new_tag,idx,2'b00}`, where `idx = cnt` (see Configuration).
  - On `mem_ack`: capture `mem_in`, go to FILL_WE.
- **FILL_WE.** One cycle with `flush_we=1`, `flush_addr={new_tag,idx,2'b00}`, `flush_in` = captured data.
  - If `cnt` is at its maximum, go to DONE; else increment `cnt` and go to FILL_RD.
- **DONE.** One cycle with `flush_mode=0` so the line's miss status re-evaluates, then go to IDLE.
- `flush_mode` is 1 in every state except IDLE and DONE.
- `dcache_stall = (state!=IDLE) | ((rdreq|wrreq) & line_miss)`.
- **CPU request dropped.** If the CPU deasserts its request mid-sequence, the sequence still completes; it is never aborted.
- **Counter wrap.** `cnt` and `idx` arithmetic is modulo 2^CACHEADDRBITS and wraps silently.
- **Reset mid-operation.** The FSM returns to IDLE immediately and any outstanding memory request is dropped. The line's own reset marks it invalid, so no corrupt hit is possible.
- **Reset values.** All outputs are 0 except `dcache_stall`, which follows its combinational equation (0 when there is no request).

## Timing
- Requests are registered outputs. `mem_ack` is sampled every cycle the request is high, including the first, so an ack in the first cycle completes the transfer.
- `mem_rdreq` and `mem_wrreq` are never high together.
- Both requests drop in the cycle after ack.
- With zero-wait memory (ack in the first request cycle):
  - Clean miss: 2·2^CACHEADDRBITS + 2 cycles from trigger to IDLE, i.e. 66 for CACHEADDRBITS=5.
  - Dirty miss: 4·2^CACHEADDRBITS + 2 cycles, i.e. 130 for CACHEADDRBITS=5.
- `dcache_stall` falls combinationally once IDLE is reached with `line_miss=0`.

## Configuration
- Macro: `DCACHE_FLUSH_CRITICAL_WORD_FIRST_EN`.
- **Defined.** Fill order is `idx = start + cnt`, wrapping. The missed word is fetched first.
- **Undefined.** `idx = cnt`, so the fill runs 0..2^CACHEADDRBITS-1.
- Write-back order is always 0 upward.
- Cycle counts are identical in both builds.

## Test plan
All scenarios use CACHEADDRBITS=5, with memory acking in the first request cycle unless stated otherwise.
- **Clean miss.** Rdreq to 0x0000_1084 with `line_miss=1`, `line_dirty=0` → 32 reads at 0x1080..0x10FC. Each is followed by `flush_we` at the same address with the returned data. Stall lasts 66 cycles.
- **Dirty miss.** `line_tag=0x05`, `line_dirty=1`, miss to 0x1084 → 32 writes to 0x0280..0x02FC carrying `line_out` words, then the 32-word fill from 0x1080.
- **Slow memory.** Ack delayed 3 cycles on every transfer → request held steady for 4 cycles each. Each dirty word costs 5 cycles; clean miss totals 162 cycles.
- **Critical word first.** Macro defined, miss to 0x1084 → first fill address 0x1084, ..., 0x10FC, then 0x1080. Last fill at 0x1080.
- **Hit and reset.** Hit request (`line_miss=0`) → controller stays IDLE and `dcache_stall=0`. Reset asserted during WB_WR → `mem_wrreq`/`flush_mode` go to 0 at once, and state is IDLE after release.
